// File: rtl/debouncer_pkg.sv
// Shared types and default timing constants for the push-button debouncer.
package debouncer_pkg;

   // Debouncer FSM states
   typedef enum logic [1:0] {
      SOLTO       = 2'd0,
      CONF_PRESS  = 2'd1,
      PRESSIONADO = 2'd2,
      CONF_SOLTA  = 2'd3
   } estado_e;

   localparam int unsigned CLK_HZ          = 50_000_000;
   localparam int unsigned DEBOUNCE_MS     = 20;
   // Stable cycles needed to accept a level change (20 ms at 50 MHz)
   localparam int unsigned DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/sincronizador.sv
// N_SYNC-stage flop chain that brings asynchronous inputs into the clock domain.
// Synchronous active-low clear; WIDTH lets the same block serve a bank of switches.
module sincronizador #(
   parameter int unsigned N_SYNC = 2,
   parameter int unsigned WIDTH  = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] sync_q [N_SYNC];

   // Shift the raw input down the chain; clear every stage on reset
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(N_SYNC); i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < int'(N_SYNC); i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign q_o = sync_q[N_SYNC-1];

endmodule

// File: rtl/debouncer_botao.sv
// Push-button debouncer: synchronises the raw button, confirms each level change with a
// consecutive-sample counter and emits a clean level plus one-cycle press/release pulses.
// Optional auto-repeat of the press pulse while held: define DEBOUNCER_BOTAO_REPEAT_EN.
module debouncer_botao #(
   parameter int unsigned N_SYNC          = 2,
   parameter int unsigned DEBOUNCE_CYCLES = debouncer_pkg::DEBOUNCE_CYCLES,
   parameter int unsigned CNT_W           = 20
`ifdef DEBOUNCER_BOTAO_REPEAT_EN
   ,
   parameter int unsigned HOLD_CYCLES     = 25_000_000,
   parameter int unsigned REPEAT_CYCLES   = 10_000_000
`endif
) (
   input  logic CLOCK_50,
   input  logic RESET_N,
   input  logic V_BT,
   output logic ESTADO,
   output logic PULSO,
   output logic SOLTOU
);

   import debouncer_pkg::*;

   localparam logic [CNT_W-1:0] CNT_ULTIMO = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             amostra;
   estado_e          estado_q;
   logic [CNT_W-1:0] cnt_q;
   logic             nivel_q;
   logic             pulso_q;
   logic             soltou_q;

`ifdef DEBOUNCER_BOTAO_REPEAT_EN
   localparam int unsigned REP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
   localparam logic [REP_W-1:0] HOLD_ULTIMO   = REP_W'(HOLD_CYCLES - 1);
   localparam logic [REP_W-1:0] REPEAT_ULTIMO = REP_W'(REPEAT_CYCLES - 1);

   logic [REP_W-1:0] rep_q;
   // 0: waiting out the initial hold delay, 1: in the periodic repeat phase
   logic             rep_fase_q;
`endif

   sincronizador #(
      .N_SYNC (N_SYNC),
      .WIDTH  (1)
   ) u_sinc (
      .clk_i  (CLOCK_50),
      .rst_ni (RESET_N),
      .d_i    (V_BT),
      .q_o    (amostra)
   );

   // Debounce FSM with registered level and pulse outputs
   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         estado_q   <= SOLTO;
         cnt_q      <= '0;
         nivel_q    <= 1'b0;
         pulso_q    <= 1'b0;
         soltou_q   <= 1'b0;
`ifdef DEBOUNCER_BOTAO_REPEAT_EN
         rep_q      <= '0;
         rep_fase_q <= 1'b0;
`endif
      end else begin
         pulso_q  <= 1'b0;
         soltou_q <= 1'b0;
         unique case (estado_q)
            SOLTO: begin
               if (amostra) begin
                  estado_q <= CONF_PRESS;
                  cnt_q    <= '0;
               end
            end
            CONF_PRESS: begin
               if (!amostra) begin
                  estado_q <= SOLTO;
                  cnt_q    <= '0;
               end else if (cnt_q == CNT_ULTIMO) begin
                  estado_q <= PRESSIONADO;
                  nivel_q  <= 1'b1;
                  pulso_q  <= 1'b1;
`ifdef DEBOUNCER_BOTAO_REPEAT_EN
                  rep_q      <= '0;
                  rep_fase_q <= 1'b0;
`endif
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            PRESSIONADO: begin
               if (!amostra) begin
                  estado_q <= CONF_SOLTA;
                  cnt_q    <= '0;
`ifdef DEBOUNCER_BOTAO_REPEAT_EN
                  rep_q      <= '0;
                  rep_fase_q <= 1'b0;
`endif
               end else begin
`ifdef DEBOUNCER_BOTAO_REPEAT_EN
                  // Initial hold delay first, then a fixed repeat period
                  if ((!rep_fase_q && rep_q == HOLD_ULTIMO) ||
                      (rep_fase_q && rep_q == REPEAT_ULTIMO)) begin
                     pulso_q    <= 1'b1;
                     rep_q      <= '0;
                     rep_fase_q <= 1'b1;
                  end else begin
                     rep_q <= rep_q + REP_W'(1);
                  end
`endif
               end
            end
            CONF_SOLTA: begin
               if (amostra) begin
                  // Release glitch: back to held, hold delay restarts from zero
                  estado_q <= PRESSIONADO;
                  cnt_q    <= '0;
`ifdef DEBOUNCER_BOTAO_REPEAT_EN
                  rep_q      <= '0;
                  rep_fase_q <= 1'b0;
`endif
               end else if (cnt_q == CNT_ULTIMO) begin
                  estado_q <= SOLTO;
                  nivel_q  <= 1'b0;
                  soltou_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: estado_q <= SOLTO;
         endcase
      end
   end

   assign ESTADO = nivel_q;
   assign PULSO  = pulso_q;
   assign SOLTOU = soltou_q;

endmodule

// File: tb/tb_debouncer_botao.sv
// Self-checking bench for debouncer_botao: directed scenarios plus random bursts,
// compared cycle by cycle against a run-length reference model.
module tb_debouncer_botao;

   localparam int N_SYNC          = 2;
   localparam int DEBOUNCE_CYCLES = 4;
   localparam int CNT_W           = 3;
   // Capture of a held edge to PULSO, in posedges
   localparam int LATENCIA        = N_SYNC + DEBOUNCE_CYCLES + 1;
`ifdef DEBOUNCER_BOTAO_REPEAT_EN
   localparam int HOLD_CYCLES     = 10;
   localparam int REPEAT_CYCLES   = 5;
   localparam int PULSOS_20       = 2;
   localparam int PULSOS_BOUNCE   = 2;
   localparam int PULSOS_40       = 6;
   localparam int PULSOS_SOLTAR40 = 1;
`else
   localparam int PULSOS_20       = 1;
   localparam int PULSOS_BOUNCE   = 1;
   localparam int PULSOS_40       = 1;
   localparam int PULSOS_SOLTAR40 = 0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   logic v_bt;
   logic estado, pulso, soltou;

   always #5 clk = ~clk;

   debouncer_botao #(
      .N_SYNC          (N_SYNC),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
`ifdef DEBOUNCER_BOTAO_REPEAT_EN
      ,
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
`endif
   ) dut (
      .CLOCK_50 (clk),
      .RESET_N  (reset_n),
      .V_BT     (v_bt),
      .ESTADO   (estado),
      .PULSO    (pulso),
      .SOLTOU   (soltou)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: input history per posedge, plus run-length of disagreeing samples
   logic hist_v[$];
   logic hist_r[$];
   int   m_run   = 0;
   int   m_hold  = -1;
   logic m_level = 1'b0;
   logic m_pulso = 1'b0;
   logic m_soltou = 1'b0;

   // Sample seen by the FSM at posedge k: input captured N_SYNC posedges earlier,
   // or 0 if any reset fell inside the synchroniser window
   function automatic logic amostra_ref(input int k);
      if (k < N_SYNC) return 1'b0;
      for (int j = k - N_SYNC; j < k; j++) begin
         if (!hist_r[j]) return 1'b0;
      end
      return hist_v[k - N_SYNC];
   endfunction

   task automatic model_step(input logic v, input logic rn);
      int   k;
      logic s;
      k = hist_v.size();
      hist_v.push_back(v);
      hist_r.push_back(rn);
      m_pulso  = 1'b0;
      m_soltou = 1'b0;
      if (!rn) begin
         m_level = 1'b0;
         m_run   = 0;
         m_hold  = -1;
      end else begin
         s = amostra_ref(k);
         // A change is accepted after DEBOUNCE_CYCLES+1 consecutive opposite samples
         if (s != m_level) m_run++;
         else m_run = 0;
         if (m_run == DEBOUNCE_CYCLES + 1) begin
            m_run   = 0;
            m_level = s;
            if (s) begin
               m_pulso = 1'b1;
               m_hold  = 0;
            end else begin
               m_soltou = 1'b1;
            end
         end else if (m_level) begin
            if (!s) begin
               m_hold = -1;
            end else begin
               if (m_hold < 0) m_hold = 0;
               else m_hold++;
`ifdef DEBOUNCER_BOTAO_REPEAT_EN
               if (m_hold == HOLD_CYCLES ||
                   (m_hold > HOLD_CYCLES && (m_hold - HOLD_CYCLES) % REPEAT_CYCLES == 0))
                  m_pulso = 1'b1;
`endif
            end
         end
      end
   endtask

   // Per-scenario observation counters
   int t_idx;
   int cnt_pulso;
   int cnt_soltou;
   int prim_pulso;
   bit estado_sempre;

   task automatic zera();
      t_idx         = 0;
      cnt_pulso     = 0;
      cnt_soltou    = 0;
      prim_pulso    = 0;
      estado_sempre = 1'b1;
   endtask

   // One clock: drive on the falling edge, update model at posedge, compare at next negedge
   task automatic tick(input logic v, input logic rn);
      v_bt    = v;
      reset_n = rn;
      @(posedge clk);
      model_step(v, rn);
      @(negedge clk);
      t_idx++;
      check("ESTADO", estado, m_level);
      check("PULSO", pulso, m_pulso);
      check("SOLTOU", soltou, m_soltou);
      check("exclusivo", pulso & soltou, 0);
      if (pulso === 1'b1) begin
         cnt_pulso++;
         if (prim_pulso == 0) prim_pulso = t_idx;
      end
      if (soltou === 1'b1) cnt_soltou++;
      if (estado !== 1'b1) estado_sempre = 1'b0;
   endtask

   initial begin
      logic [8:0] padrao;
      padrao = 9'b100110011;

      // Reset held with button pressed, then a press accepted after the full latency
      zera();
      repeat (3) tick(1'b1, 1'b0);
      check("rst_pulso", cnt_pulso, 0);
      check("rst_soltou", cnt_soltou, 0);
      zera();
      repeat (20) tick(1'b1, 1'b1);
      check("rst_latencia", prim_pulso, LATENCIA);
      zera();
      repeat (20) tick(1'b0, 1'b1);
      check("rst_solta", cnt_soltou, 1);

      // Clean press and clean release
      zera();
      repeat (20) tick(1'b1, 1'b1);
      check("press_n", cnt_pulso, PULSOS_20);
      check("press_lat", prim_pulso, LATENCIA);
      zera();
      repeat (20) tick(1'b0, 1'b1);
      check("solta_n", cnt_soltou, 1);
      check("solta_pulso", cnt_pulso, 0);
      check("solta_estado", estado, 0);

      // Bounce 1,0,1,0,1 at 2-cycle intervals, then held
      zera();
      for (int i = 0; i < 9; i++) tick(padrao[i], 1'b1);
      check("bounce_toggle", cnt_pulso, 0);
      repeat (20) tick(1'b1, 1'b1);
      check("bounce_lat", prim_pulso, 9 + LATENCIA - 1);
      check("bounce_n", cnt_pulso, PULSOS_BOUNCE);

      // Release glitch of 3 cycles while pressed
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      zera();
      tick(1'b0, 1'b1);
      repeat (10) tick(1'b1, 1'b1);
      check("glitch_soltou", cnt_soltou, 0);
      check("glitch_pulso", cnt_pulso, 0);
      check("glitch_estado", estado_sempre, 1);
      repeat (20) tick(1'b0, 1'b1);

      // Reset during the second cycle of press confirmation
      zera();
      repeat (4) tick(1'b1, 1'b1);
      tick(1'b1, 1'b0);
      check("rstmeio_pulso", cnt_pulso, 0);
      check("rstmeio_estado", estado, 0);
      zera();
      repeat (15) tick(1'b1, 1'b1);
      check("rstmeio_lat", prim_pulso, LATENCIA);
      repeat (20) tick(1'b0, 1'b1);

      // Long hold: auto-repeat when enabled, otherwise a single pulse
      zera();
      repeat (40) tick(1'b1, 1'b1);
      check("hold_n", cnt_pulso, PULSOS_40);
      check("hold_lat", prim_pulso, LATENCIA);
      zera();
      repeat (20) tick(1'b0, 1'b1);
      check("hold_solta_pulso", cnt_pulso, PULSOS_SOLTAR40);
      check("hold_solta_n", cnt_soltou, 1);

      // Random bursts of varying length with occasional resets
      for (int seg = 0; seg < 80; seg++) begin
         logic nivel;
         int   len;
         nivel = 1'($urandom_range(0, 1));
         len   = (($urandom_range(0, 3)) == 0) ? $urandom_range(6, 14) : $urandom_range(1, 5);
         if ($urandom_range(0, 19) == 0) tick(nivel, 1'b0);
         for (int i = 0; i < len; i++) tick(nivel, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
